// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory stage: size codes, FSM encoding, lane count
// and the load-extraction helper used on the read path.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    localparam int NUM_LANES = 4;

    typedef struct packed {
        logic [1:0] off;
        logic [1:0] size;
        logic       uns;
    } ld_ctrl_t;

    // Move the addressed lane(s) down to bit 0, then sign- or zero-extend.
    function automatic logic [31:0] load_extract(input logic [31:0] word, input ld_ctrl_t c);
        logic [31:0] sh;
        sh = word >> {c.off, 3'b000};
        case (c.size)
            SZ_BYTE: return c.uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            SZ_HALF: return c.uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: return word;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_unit_bank.sv
// Four byte-wide RAM lanes sharing one word index, per-lane write enable and a
// registered read that holds its value until the next read enable.
module dmem_bank
    import dmem_pkg::*;
#(
    parameter int    DEPTH_LOG2 = 10,
    parameter string INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic [NUM_LANES-1:0]  lane_we,
    input  logic                  rd_en,
    input  logic [DEPTH_LOG2-1:0] idx,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        logic [7:0] mem [2**DEPTH_LOG2];
        logic [7:0] rd_q;

        always_ff @(posedge clk) begin
            if (lane_we[k]) mem[idx] <= wdata[8*k +: 8];
            if (rd_en)      rd_q     <= mem[idx];
        end

        assign rdata[8*k +: 8] = rd_q;
    end

endmodule

// File: rtl/data_mem_unit.sv
// MIPS data-memory stage: alignment check, byte-lane steering, load extension,
// fixed-latency response pipe and the WAIT FSM that throttles requests.
module data_mem_unit
    import dmem_pkg::*;
#(
    parameter int    DEPTH_LOG2 = 10,
    parameter int    RD_LATENCY = 1,
    parameter string INIT_FILE  = ""
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        addr_err,
    output logic        busy
);

    localparam logic [1:0] LAT_M1 = 2'(RD_LATENCY - 1);

    logic [0:0]            state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic [RD_LATENCY-1:0] vld_sr_q, vld_sr_d;
    ld_ctrl_t              ctrl_p1_q, ctrl_p1_d;
    logic [31:0]           hold_q, hold_d;

    logic                  ready_int, acc, misalign, st_go, ld_go;
    logic [NUM_LANES-1:0]  be;
    logic [31:0]           wdata_rep, bank_rdata, ext_p1, last_dat;
    logic                  last_vld;
    logic                  unused_addr_hi;

    assign unused_addr_hi = ^req_addr[31:DEPTH_LOG2+2];

    // The final WAIT cycle (count exhausted) is also the response cycle and may accept.
    assign ready_int = (state_q == ST_IDLE) || (cnt_q == 2'd0);
    assign acc       = req_valid && ready_int && resetn;

    always_comb begin
        misalign  = 1'b0;
        be        = 4'b0000;
        wdata_rep = req_wdata;
        case (req_size)
            SZ_BYTE: begin
                be        = 4'b0001 << req_addr[1:0];
                wdata_rep = {4{req_wdata[7:0]}};
            end
            SZ_HALF: begin
                misalign  = req_addr[0];
                be        = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{req_wdata[15:0]}};
            end
            SZ_WORD: begin
                misalign  = |req_addr[1:0];
                be        = 4'b1111;
            end
            default: misalign = 1'b1;
        endcase
        st_go = acc && req_we && !misalign;
        ld_go = acc && !req_we && !misalign;
    end

    dmem_bank #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .INIT_FILE  (INIT_FILE)
    ) u_bank (
        .clk     (clk),
        .lane_we (st_go ? be : 4'b0000),
        .rd_en   (ld_go),
        .idx     (req_addr[DEPTH_LOG2+1:2]),
        .wdata   (wdata_rep),
        .rdata   (bank_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_WAIT && cnt_q != 2'd0) begin
            cnt_d = cnt_q - 2'd1;
        end else if (ld_go && RD_LATENCY > 1) begin
            state_d = ST_WAIT;
            cnt_d   = LAT_M1;
        end else begin
            state_d = ST_IDLE;
            cnt_d   = 2'd0;
        end
        err_d     = acc && misalign;
        vld_sr_d  = (vld_sr_q << 1) | RD_LATENCY'(ld_go);
        ctrl_p1_d = ld_go ? ld_ctrl_t'{off: req_addr[1:0], size: req_size, uns: req_unsigned}
                          : ctrl_p1_q;
        hold_d    = last_vld ? last_dat : hold_q;
    end

    // p1: bank word is valid one cycle after accept; extract it here
    assign ext_p1   = load_extract(bank_rdata, ctrl_p1_q);
    assign last_vld = vld_sr_q[RD_LATENCY-1];

    if (RD_LATENCY > 1) begin : g_pipe
        logic [31:0] dat_sr_q [RD_LATENCY-1];
        logic [31:0] dat_sr_d [RD_LATENCY-1];

        always_comb begin
            dat_sr_d[0] = ext_p1;
            for (int k = 1; k < RD_LATENCY - 1; k++) dat_sr_d[k] = dat_sr_q[k-1];
        end

        always_ff @(posedge clk) begin
            if (!resetn) begin
                for (int k = 0; k < RD_LATENCY - 1; k++) dat_sr_q[k] <= '0;
            end else begin
                dat_sr_q <= dat_sr_d;
            end
        end

        assign last_dat = dat_sr_q[RD_LATENCY-2];
    end else begin : g_nopipe
        assign last_dat = ext_p1;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 2'd0;
            err_q     <= 1'b0;
            vld_sr_q  <= '0;
            ctrl_p1_q <= '0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            vld_sr_q  <= vld_sr_d;
            ctrl_p1_q <= ctrl_p1_d;
            hold_q    <= hold_d;
        end
    end

    // Outputs read as idle while reset is held, so an in-flight load never surfaces.
    assign req_ready  = ready_int || !resetn;
    assign resp_valid = last_vld && resetn;
    assign resp_rdata = !resetn ? 32'h0 : (last_vld ? last_dat : hold_q);
    assign addr_err   = err_q && resetn;
    assign busy       = (state_q != ST_IDLE) && resetn;

endmodule
